sys_check_pipe: RTL
===================

# sys_check_pipe

Registered, handshaked successor to the combinational system-instruction checker in the execute stage. It accepts one system op per handshake and validates CSR number, write permission, privilege, counter-enable and mstatus TVM/TW/TSR gating. The set of implemented hardware performance counters and XLEN are parametrised. WFI is held in a wait state until an interrupt is pending or the TW timeout expires. The result goes to the commit/trap logic through a valid/ready pair.

## Interface
- XLEN, 32: 32 or 64. When 32, the high-half counter CSRs (…h) are implemented; when 64 they decode as invalid.
- NUM_HPM, 4: 0..29. Number of implemented hpmcounter3.. / mhpmcounter3.. / mhpmevent3.. CSRs.
- WFI_TW_LIMIT, 16: ≥1. WAIT cycles before a TW-gated WFI from below M mode turns illegal.
- HAS_UTRAP, 0: when 0, URET is illegal.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_log_fd  in  32  log file descriptor (simulation only)
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_op  in  decode_sys_op_t  system op
- i_ps  in  program_state_t  current privilege (i_ps.priv)
- i_csr  in  12  CSR number
- i_rs1_is_zero  in  1  rs1/uimm is zero
- i_tvm, i_tw, i_tsr  in  1 each  mstatus fields
- i_mcounteren, i_scounteren  in  32 each  counter enables
- i_irq_pending  in  1  any enabled interrupt pending
- i_flush  in  1  pipeline flush
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_bad_csr, o_trap, o_illegal  out  1 each  result flags, registered

## Operation
- FSM states: IDLE, HOLD (result held), WAIT (WFI).
- o_ready is 1 in IDLE, and in HOLD when i_ready is 1. It is 0 in WAIT.
- On accept, the checks below are evaluated and registered. WFI that is not illegal goes to WAIT; every other op goes to HOLD.
- valid_num:
  - Base set: 040; C00–C02; 100, 104–106; 140–144; 180; F11–F14; 300–306; 340–344; 320; B00, B02; 3F0, 3F1.
  - For k < NUM_HPM: C03+k, B03+k, 323+k.
  - If XLEN==32 also: C80–C82, B80, B82, C83+k, B83+k.
- req_write: SWAP, or READ_SET/READ_CLEAR with rs1 ≠ 0. If req_write and csr[11:10]==11, the access is bad.
- priv check: csr[9:8] ≤ priv. M mode passes all.
- Counter gate, for csr in C00–C1F or C80–C9F with n = csr[4:0]:
  - S mode requires i_mcounteren[n].
  - U mode requires i_mcounteren[n] & i_scounteren[n].
- satp (180) accessed in S mode with i_tvm=1 is bad.
- o_bad_csr = CSR op & any check fails.
- o_illegal is set by any of:
  - MRET with priv≠M
  - SRET with priv=U
  - SRET in S mode with i_tsr
  - URET with HAS_UTRAP=0
  - WFI from U mode
  - WFI timeout
- o_trap = ECALL | EBREAK | MRET | SRET | URET when not illegal, or WFI wake.
- Flags are mutually exclusive. Non-system ops produce all flags 0 with o_valid=1.
- WAIT behaviour:
  - The counter (width $clog2(WFI_TW_LIMIT+1)) clears on entry and increments each WAIT cycle.
  - If i_irq_pending=1: go to HOLD with o_trap=1.
  - Otherwise, if i_tw & priv≠M and the counter == WFI_TW_LIMIT-1: go to HOLD with o_illegal=1.
  - In M mode, or with i_tw=0, WAIT never times out.
  - If irq and timeout occur in the same cycle, irq wins.
- i_flush in any state: next state IDLE, o_valid=0, counter cleared. A request presented in a flush cycle is dropped.
- HOLD with i_ready=1 and a new accept: back-to-back, the new result is loaded.

## Timing
- Reset: state IDLE, o_valid=0, o_bad_csr=o_trap=o_illegal=0, counter 0, o_ready=1.
- Non-WFI: accept at cycle N gives o_valid at N+1, held until i_ready. Throughput is 1 op/cycle with i_ready=1.
- WFI: accept at N, WAIT from N+1.
  - If i_irq_pending is first high at cycle M ≥ N+1, o_valid at M+1.
  - On timeout, o_valid at N+1+WFI_TW_LIMIT.
- o_ready is combinational from state and i_ready only; there is no path from i_valid.
- Asynchronous reset mid-WAIT or mid-HOLD discards the op immediately.

## Test plan
- U mode, csrrs C00 with rs1=0, mcounteren=1, scounteren=0 -> o_valid at N+1, o_bad_csr=1. Same with scounteren=1 -> all flags 0.
- S mode, csrrw 180 with i_tvm=1 -> o_bad_csr=1. M mode csrrw C03 (NUM_HPM=4) -> o_bad_csr=1 (read-only). csrrs C07 with rs1=0 -> bad (k=4 not implemented).
- XLEN=64: csrrs C80 in M mode -> o_bad_csr=1. XLEN=32 -> 0.
- S mode WFI, i_tw=1, WFI_TW_LIMIT=16, no irq -> o_ready=0 during WAIT; o_valid at N+17 with o_illegal=1. Repeat with irq asserted at N+5 -> o_valid at N+6, o_trap=1.
- SRET in S mode with i_tsr=1 -> o_illegal=1. MRET in U mode -> o_illegal=1. ECALL in U mode -> o_trap=1.
- i_ready=0 for 3 cycles in HOLD -> result stable, o_ready=0. Flush during WAIT -> o_valid=0, o_ready=1 next cycle. i_rst_n low mid-HOLD -> outputs 0 immediately.

Source files
------------

// File: rtl/sys_check_pipe.sv
// Registered system-instruction checker: validates CSR accesses and privileged
// ops, holds WFI until an interrupt or TW timeout, and returns a valid/ready result.
package sys_check_pkg;
  typedef enum logic [3:0] {
    SYS_NONE           = 4'd0,
    SYS_CSR_SWAP       = 4'd1,
    SYS_CSR_READ_SET   = 4'd2,
    SYS_CSR_READ_CLEAR = 4'd3,
    SYS_ECALL          = 4'd4,
    SYS_EBREAK         = 4'd5,
    SYS_MRET           = 4'd6,
    SYS_SRET           = 4'd7,
    SYS_URET           = 4'd8,
    SYS_WFI            = 4'd9
  } decode_sys_op_t;

  typedef struct packed {
    logic [1:0] priv;
  } program_state_t;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;
endpackage

module sys_check_pipe
  import sys_check_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_HPM      = 4,
  parameter int WFI_TW_LIMIT = 16,
  parameter int HAS_UTRAP    = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [31:0]    i_log_fd,
  input  logic           i_valid,
  output logic           o_ready,
  input  decode_sys_op_t i_op,
  input  program_state_t i_ps,
  input  logic [11:0]    i_csr,
  input  logic           i_rs1_is_zero,
  input  logic           i_tvm,
  input  logic           i_tw,
  input  logic           i_tsr,
  input  logic [31:0]    i_mcounteren,
  input  logic [31:0]    i_scounteren,
  input  logic           i_irq_pending,
  input  logic           i_flush,
  output logic           o_valid,
  input  logic           i_ready,
  output logic           o_bad_csr,
  output logic           o_trap,
  output logic           o_illegal
);

  localparam int            CW       = $clog2(WFI_TW_LIMIT + 1);
  localparam logic [CW-1:0] TW_LAST  = CW'(WFI_TW_LIMIT - 1);
  localparam logic [4:0]    HPM_N    = 5'(NUM_HPM);
  localparam logic          IS_RV32  = (XLEN == 32);
  localparam logic          UTRAP_ON = (HAS_UTRAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic          bad_q, bad_d;
  logic          trap_q, trap_d;
  logic          illegal_q, illegal_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       is_csr_s, req_write_s, priv_m_s, priv_fail_s;
  logic       cnt_gate_s, cnt_ok_s, satp_fail_s, bad_s;
  logic       illegal_s, trap_s, accept_s, timeout_s;
  logic [4:0] cnt_idx_s;

  // The log descriptor only matters to simulation-side tracing.
  logic unused_log_fd_s;
  assign unused_log_fd_s = ^i_log_fd;

  // Wrapping subtraction turns the range test into one unsigned compare.
  function automatic logic in_range(input logic [11:0] csr, input logic [11:0] base,
                                    input logic [4:0] count);
    logic [11:0] offs;
    offs = csr - base;
    return offs < {7'd0, count};
  endfunction

  function automatic logic csr_implemented(input logic [11:0] csr);
    logic ok;
    ok = (csr == 12'h040) | in_range(csr, 12'hC00, 5'd3) | (csr == 12'h100)
       | in_range(csr, 12'h104, 5'd3) | in_range(csr, 12'h140, 5'd5)
       | (csr == 12'h180) | in_range(csr, 12'hF11, 5'd4)
       | in_range(csr, 12'h300, 5'd7) | in_range(csr, 12'h340, 5'd5)
       | (csr == 12'h320) | (csr == 12'hB00) | (csr == 12'hB02)
       | (csr == 12'h3F0) | (csr == 12'h3F1)
       | in_range(csr, 12'hC03, HPM_N) | in_range(csr, 12'hB03, HPM_N)
       | in_range(csr, 12'h323, HPM_N);
    ok = ok | (IS_RV32 & (in_range(csr, 12'hC80, 5'd3) | (csr == 12'hB80)
                        | (csr == 12'hB82) | in_range(csr, 12'hC83, HPM_N)
                        | in_range(csr, 12'hB83, HPM_N)));
    return ok;
  endfunction

  assign o_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_ready);
  assign accept_s = i_valid && o_ready;

  // Request checks, evaluated on the presented op every cycle.
  always_comb begin
    is_csr_s    = (i_op == SYS_CSR_SWAP) || (i_op == SYS_CSR_READ_SET) ||
                  (i_op == SYS_CSR_READ_CLEAR);
    req_write_s = (i_op == SYS_CSR_SWAP) ||
                  (((i_op == SYS_CSR_READ_SET) || (i_op == SYS_CSR_READ_CLEAR)) &&
                   !i_rs1_is_zero);
    priv_m_s    = (i_ps.priv == PRIV_M);
    priv_fail_s = !priv_m_s && (i_csr[9:8] > i_ps.priv);
    cnt_idx_s   = i_csr[4:0];
    cnt_gate_s  = (i_csr[11:5] == 7'h60) || (i_csr[11:5] == 7'h64);
    case (i_ps.priv)
      PRIV_M:  cnt_ok_s = 1'b1;
      PRIV_U:  cnt_ok_s = i_mcounteren[cnt_idx_s] && i_scounteren[cnt_idx_s];
      default: cnt_ok_s = i_mcounteren[cnt_idx_s];
    endcase
    satp_fail_s = (i_csr == 12'h180) && (i_ps.priv == PRIV_S) && i_tvm;
    bad_s       = is_csr_s && (!csr_implemented(i_csr) ||
                               (req_write_s && (i_csr[11:10] == 2'b11)) ||
                               priv_fail_s || (cnt_gate_s && !cnt_ok_s) || satp_fail_s);
    case (i_op)
      SYS_MRET: illegal_s = !priv_m_s;
      SYS_SRET: illegal_s = (i_ps.priv == PRIV_U) || ((i_ps.priv == PRIV_S) && i_tsr);
      SYS_URET: illegal_s = !UTRAP_ON;
      SYS_WFI:  illegal_s = (i_ps.priv == PRIV_U);
      default:  illegal_s = 1'b0;
    endcase
    case (i_op)
      SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_SRET, SYS_URET: trap_s = !illegal_s;
      default:                                            trap_s = 1'b0;
    endcase
    timeout_s = i_tw && !priv_m_s && (cnt_q == TW_LAST);
  end

  // Next-state and next-result logic.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    bad_d     = bad_q;
    trap_d    = trap_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (i_flush) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      bad_d     = 1'b0;
      trap_d    = 1'b0;
      illegal_d = 1'b0;
      cnt_d     = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
            if ((i_op == SYS_WFI) && !illegal_s) begin
              state_d   = ST_WAIT;
              valid_d   = 1'b0;
              bad_d     = 1'b0;
              trap_d    = 1'b0;
              illegal_d = 1'b0;
              cnt_d     = {CW{1'b0}};
            end else begin
              state_d   = ST_HOLD;
              valid_d   = 1'b1;
              bad_d     = bad_s;
              trap_d    = trap_s;
              illegal_d = illegal_s;
            end
          end else if ((state_q == ST_HOLD) && i_ready) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            bad_d     = 1'b0;
            trap_d    = 1'b0;
            illegal_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q + CW'(1);
          // A pending interrupt beats a simultaneous timeout.
          if (i_irq_pending) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            trap_d  = 1'b1;
          end else if (timeout_s) begin
            state_d   = ST_HOLD;
            valid_d   = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          bad_d     = 1'b0;
          trap_d    = 1'b0;
          illegal_d = 1'b0;
          cnt_d     = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, result and wait-counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      bad_q     <= 1'b0;
      trap_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      bad_q     <= bad_d;
      trap_q    <= trap_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_bad_csr = bad_q;
  assign o_trap    = trap_q;
  assign o_illegal = illegal_q;

endmodule
